// File: rtl/four_disp_pkg.sv
// Shared constants and helpers for the four-digit display scanner.
// Holds digit count, nibble width, the all-off anode pattern, and onehot_low().
package four_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  function automatic logic [NUM_DIGITS-1:0] onehot_low(
    input logic [1:0] idx
  );
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/slot_tick_gen.sv
// Digit-slot prescaler: counts 0..TICK_DIV-1 while en is high.
// Ports: clk, rst (async high), en; tick (terminal count this cycle),
// in_dead / slot_start describe the count that follows the coming edge.
module slot_tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic in_dead,
  output logic slot_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW:0]   DEAD_C = (CW + 1)'(DEAD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick       = en && (cnt == LAST);
  // Look-ahead so the top can register outputs that match the new count.
  assign in_dead    = {1'b0, cnt_nxt} < DEAD_C;
  assign slot_start = (cnt_nxt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/four_digit_scanner.sv
// Time-multiplexes a 16-bit hex value over four common-anode digits.
// In: clk, rst, value, dp, load, lz_blank. Out: nib, dp_ci, an, digit, frame_start.
module four_digit_scanner
  import four_disp_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEAD     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [NIB_W-1:0]      nib,
  output logic                  dp_ci,
  output logic [NUM_DIGITS-1:0] an,
  output logic [1:0]            digit,
  output logic                  frame_start
);

  // armed: the edge that releases reset is a warm-up edge; the
  // scan starts on the next cycle with cnt=0, digit=0.
  logic        armed;
  logic        tick;
  logic        in_dead;
  logic        slot_start;
  logic        boundary;
  logic        blank_nxt;
  logic [1:0]  digit_nxt;
  logic [15:0] pv;
  logic [15:0] sv;
  logic [15:0] sv_nxt;
  logic [3:0]  pdp;
  logic [3:0]  sdp;
  logic [3:0]  sdp_nxt;

  slot_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DEAD     (DEAD)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .en         (armed),
    .tick       (tick),
    .in_dead    (in_dead),
    .slot_start (slot_start)
  );

  assign boundary  = tick && (digit == 2'd3);
  assign digit_nxt = tick ? digit + 2'd1 : digit;
  // Shadow takes the pending value as it was before this edge.
  assign sv_nxt    = boundary ? pv  : sv;
  assign sdp_nxt   = boundary ? pdp : sdp;

  always_comb begin
    blank_nxt = 1'b0;
    unique case (digit_nxt)
      2'd1:    blank_nxt = (sv_nxt[15:4]  == '0);
      2'd2:    blank_nxt = (sv_nxt[15:8]  == '0);
      2'd3:    blank_nxt = (sv_nxt[15:12] == '0);
      default: blank_nxt = 1'b0;
    endcase
    blank_nxt = blank_nxt && lz_blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      digit       <= '0;
      pv          <= '0;
      pdp         <= '0;
      sv          <= '0;
      sdp         <= '0;
      nib         <= '0;
      dp_ci       <= 1'b0;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (load) begin
        pv  <= value;
        pdp <= dp;
      end
      digit       <= digit_nxt;
      sv          <= sv_nxt;
      sdp         <= sdp_nxt;
      nib         <= sv_nxt[NIB_W*digit_nxt +: NIB_W];
      dp_ci       <= sdp_nxt[digit_nxt];
      an          <= (in_dead || blank_nxt) ? AN_OFF
                                            : onehot_low(digit_nxt);
      frame_start <= slot_start && (digit_nxt == 2'd0);
    end
  end

endmodule
